// File: rtl/link_tx_arbiter_if.sv
// Request/link/credit bundle between the requesters, the tx arbiter and the serializer.
interface link_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CREDITS = 4
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      link_valid;
  logic [DATA_W-1:0]         link_data;
  logic [2:0]                link_src;
  logic                      link_ready;
  logic                      credit_ret;
  logic                      flush;
  logic                      flush_done;
  logic [CW-1:0]             credit_cnt;
  logic                      credit_err;

  modport master (
    output req_valid, req_data, link_ready, credit_ret, flush,
    input  req_ready, link_valid, link_data, link_src, flush_done, credit_cnt, credit_err
  );

  modport slave (
    input  req_valid, req_data, link_ready, credit_ret, flush,
    output req_ready, link_valid, link_data, link_src, flush_done, credit_cnt, credit_err
  );
endinterface

// File: rtl/link_tx_arbiter.sv
// Credit-gated tx byte arbiter, round-robin (fixed priority with LINK_TX_ARBITER_FIXED_PRIO_EN), with flush drain.
// Latency req_valid->link_valid 1 cycle, 1 byte/cycle peak; byte held until link_ready, req_ready low at zero credits.
module link_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CREDITS = 4
) (
  input logic          clk,
  input logic          rst,
  link_tx_arbiter_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_e;

  state_e            state_q, state_d;
  logic              link_valid_q, link_valid_d;
  logic [DATA_W-1:0] link_data_q, link_data_d;
  logic [2:0]        link_src_q, link_src_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic              credit_err_q, credit_err_d;
  logic              flush_done_q, flush_done_d;

  logic [DATA_W-1:0] data_arr [8];
  logic              win_found;
  logic [2:0]        win_idx;
  logic              grant;

  always_comb begin
    for (int i = 0; i < 8; i++) data_arr[i] = '0;
    for (int i = 0; i < NUM_REQ; i++) data_arr[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

`ifdef LINK_TX_ARBITER_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    // Scan downward so the lowest valid index is the last one written.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        win_found = 1'b1;
        win_idx   = 3'(k);
      end
    end
  end
`else
  localparam logic [2:0] LAST = 3'(NUM_REQ - 1);
  logic [2:0] rr_ptr_q, rr_ptr_d;
  logic [2:0] cand;
  logic [7:0] vld_pad;

  always_comb begin
    vld_pad = '0;
    vld_pad[NUM_REQ-1:0] = bus.req_valid;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST) ? 3'd0 : cand + 3'd1;
      if (!win_found && vld_pad[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  assign grant = ((state_q == IDLE) || (state_q == SEND && bus.link_ready)) &&
                 !bus.flush && (credit_q != '0) && win_found;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && win_idx == 3'(i)) bus.req_ready[i] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    link_valid_d = link_valid_q;
    link_data_d  = link_data_q;
    link_src_d   = link_src_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    flush_done_d = 1'b0;
`ifndef LINK_TX_ARBITER_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
`endif

    if (grant) begin
      state_d      = SEND;
      link_valid_d = 1'b1;
      link_data_d  = data_arr[win_idx];
      link_src_d   = win_idx;
`ifndef LINK_TX_ARBITER_FIXED_PRIO_EN
      rr_ptr_d     = win_idx;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.flush) state_d = DRAIN;
        SEND: begin
          if (bus.link_ready) begin
            link_valid_d = 1'b0;
            state_d      = bus.flush ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          // Every credit back means the downstream buffer is empty.
          if (credit_q == CRED_MAX) begin
            flush_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (grant && !bus.credit_ret) begin
      credit_d = credit_q - CW'(1);
    end else if (!grant && bus.credit_ret) begin
      if (credit_q == CRED_MAX) credit_err_d = 1'b1;
      else                      credit_d     = credit_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      link_src_q   <= '0;
      credit_q     <= CRED_MAX;
      credit_err_q <= 1'b0;
      flush_done_q <= 1'b0;
`ifndef LINK_TX_ARBITER_FIXED_PRIO_EN
      rr_ptr_q     <= LAST;
`endif
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      link_src_q   <= link_src_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      flush_done_q <= flush_done_d;
`ifndef LINK_TX_ARBITER_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign bus.link_valid = link_valid_q;
  assign bus.link_data  = link_data_q;
  assign bus.link_src   = link_src_q;
  assign bus.credit_cnt = credit_q;
  assign bus.credit_err = credit_err_q;
  assign bus.flush_done = flush_done_q;

  a_credit_range: assert property (@(posedge clk) disable iff (rst) credit_q <= CRED_MAX);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(grant && credit_q == '0));
endmodule

// File: tb/tb_link_tx_arbiter.sv
// Bench for link_tx_arbiter: vector table, directed corner sequences, and random traffic against a queue-free reference model.
module tb_link_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CR = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  link_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .CREDITS(CR)) bus ();
  link_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .CREDITS(CR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: credits as an integer, one flag for "byte held on link", one for "draining".
  int         m_cred, m_src, m_rr, m_last_w;
  bit         m_err, m_hold, m_drain, m_fdone;
  logic [7:0] m_data;

  typedef struct {
    logic [3:0] vld;
    logic       lrdy;
    logic       cret;
    logic [3:0] e_rdy;
    logic       e_lv;
    logic [2:0] e_src;
    logic [7:0] e_dat;
    logic [2:0] e_cred;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit vbit(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  function automatic logic [7:0] getdat(input int i);
    return 8'(bus.req_data >> (i * 8));
  endfunction

  task automatic setdat(input int i, input logic [7:0] d);
    bus.req_data = (bus.req_data & ~(32'hFF << (i * 8))) | (32'(d) << (i * 8));
  endtask

  function automatic int model_winner();
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (m_rr + k) % N;
      if (vbit(bus.req_valid, i)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cred = CR; m_err = 0; m_hold = 0; m_data = '0; m_src = 0;
    m_rr = N - 1; m_drain = 0; m_fdone = 0; m_last_w = -1;
  endtask

  // Compare everything against the model mid-cycle, advance the model, then move to just after the next edge.
  task automatic tick();
    int w;
    bit g, fd_n;
    @(negedge clk);
    w = model_winner();
    g = (!m_hold || bus.link_ready) && !m_drain && !bus.flush && m_cred > 0 && w >= 0;
    chk("req_ready",  32'(bus.req_ready),  g ? (32'd1 << w) : 32'd0);
    chk("link_valid", 32'(bus.link_valid), 32'(m_hold));
    chk("link_data",  32'(bus.link_data),  32'(m_data));
    chk("link_src",   32'(bus.link_src),   m_src);
    chk("credit_cnt", 32'(bus.credit_cnt), m_cred);
    chk("credit_err", 32'(bus.credit_err), 32'(m_err));
    chk("flush_done", 32'(bus.flush_done), 32'(m_fdone));
    if (rst) begin
      model_reset();
    end else begin
      m_last_w = g ? w : -1;
      fd_n = m_drain && m_cred == CR;
      if (g && !bus.credit_ret) m_cred--;
      else if (!g && bus.credit_ret) begin
        if (m_cred == CR) m_err = 1;
        else m_cred++;
      end
      if (g) begin
        m_hold = 1; m_data = getdat(w); m_src = w; m_rr = w;
      end else if (m_hold && bus.link_ready) begin
        m_hold = 0;
        if (bus.flush) m_drain = 1;
      end else if (!m_hold && !m_drain && bus.flush) begin
        m_drain = 1;
      end
      if (fd_n) m_drain = 0;
      m_fdone = fd_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [3:0] v, input logic lr, input logic cr, input logic fl);
    bus.req_valid  = v;
    bus.link_ready = lr;
    bus.credit_ret = cr;
    bus.flush      = fl;
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v;
    logic       fl, lr, cr;

    rst = 1'b1;
    bus.req_valid = '0; bus.req_data = '0; bus.link_ready = 1'b0;
    bus.credit_ret = 1'b0; bus.flush = 1'b0;
    @(posedge clk); #1;
    model_reset();
    drv(4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    chk("rst_link_valid", 32'(bus.link_valid), 0);
    chk("rst_link_data",  32'(bus.link_data),  0);
    chk("rst_link_src",   32'(bus.link_src),   0);
    chk("rst_credit_cnt", 32'(bus.credit_cnt), 4);
    chk("rst_credit_err", 32'(bus.credit_err), 0);
    chk("rst_flush_done", 32'(bus.flush_done), 0);

    // Round-robin over all four, credit returned two cycles after each grant.
    tbl[0] = '{4'hF, 1'b1, 1'b0, 4'b0001, 1'b0, 3'd0, 8'h00, 3'd4};
    tbl[1] = '{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 3'd0, 8'h10, 3'd3};
    tbl[2] = '{4'hF, 1'b1, 1'b1, 4'b0100, 1'b1, 3'd1, 8'h21, 3'd2};
    tbl[3] = '{4'hF, 1'b1, 1'b1, 4'b1000, 1'b1, 3'd2, 8'h32, 3'd2};
    tbl[4] = '{4'hF, 1'b1, 1'b1, 4'b0001, 1'b1, 3'd3, 8'h43, 3'd2};
    tbl[5] = '{4'h0, 1'b1, 1'b1, 4'b0000, 1'b1, 3'd0, 8'h10, 3'd2};
    tbl[6] = '{4'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 3'd0, 8'h10, 3'd3};
    tbl[7] = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h10, 3'd4};
    bus.req_data = 32'h43322110;
    for (int r = 0; r < 8; r++) begin
      drv(tbl[r].vld, tbl[r].lrdy, tbl[r].cret, 1'b0);
      chk($sformatf("vec%0d_req_ready", r),  32'(bus.req_ready),  32'(tbl[r].e_rdy));
      chk($sformatf("vec%0d_link_valid", r), 32'(bus.link_valid), 32'(tbl[r].e_lv));
      chk($sformatf("vec%0d_link_src", r),   32'(bus.link_src),   32'(tbl[r].e_src));
      chk($sformatf("vec%0d_link_data", r),  32'(bus.link_data),  32'(tbl[r].e_dat));
      chk($sformatf("vec%0d_credit_cnt", r), 32'(bus.credit_cnt), 32'(tbl[r].e_cred));
      tick();
    end

    // Single byte held under link_ready=0 for three cycles.
    bus.req_data = 32'h00050000;
    drv(4'b0100, 1'b0, 1'b0, 1'b0);
    chk("hold_grant", 32'(bus.req_ready), 32'b0100);
    tick();
    for (int k = 0; k < 3; k++) begin
      drv(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("hold_valid", 32'(bus.link_valid), 1);
      chk("hold_data",  32'(bus.link_data),  32'h05);
      chk("hold_src",   32'(bus.link_src),   2);
      chk("hold_cred",  32'(bus.credit_cnt), 3);
      tick();
    end
    drv(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    chk("hold_accepted", 32'(bus.link_valid), 0);
    chk("hold_cred_after", 32'(bus.credit_cnt), 3);
    drv(4'b0000, 1'b0, 1'b1, 1'b0);
    tick();

    // Credit exhaustion from requester 1, resume one cycle after a credit returns.
    for (int n = 0; n < 4; n++) begin
      setdat(1, 8'(8'hA0 + n));
      drv(4'b0010, 1'b1, 1'b0, 1'b0);
      chk("exh_grant", 32'(bus.req_ready), 32'b0010);
      tick();
    end
    setdat(1, 8'hA4);
    drv(4'b0010, 1'b1, 1'b0, 1'b0);
    chk("exh_no_ready", 32'(bus.req_ready), 0);
    chk("exh_cred0", 32'(bus.credit_cnt), 0);
    chk("exh_last_data", 32'(bus.link_data), 32'hA3);
    tick();
    drv(4'b0010, 1'b1, 1'b0, 1'b0);
    chk("exh_valid_drop", 32'(bus.link_valid), 0);
    chk("exh_no_ready2", 32'(bus.req_ready), 0);
    tick();
    drv(4'b0010, 1'b1, 1'b1, 1'b0);
    chk("exh_ret_cycle", 32'(bus.req_ready), 0);
    tick();
    drv(4'b0010, 1'b1, 1'b0, 1'b0);
    chk("exh_resume", 32'(bus.req_ready), 32'b0010);
    tick();
    chk("exh_fifth", 32'(bus.link_data), 32'hA4);
    drv(4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drv(4'b0000, 1'b0, 1'b1, 1'b0);
      tick();
    end

    // Grant and credit return in the same cycle at two credits.
    setdat(0, 8'h77);
    drv(4'b0001, 1'b1, 1'b0, 1'b0); tick();
    drv(4'b0001, 1'b1, 1'b0, 1'b0); tick();
    drv(4'b0001, 1'b1, 1'b1, 1'b0);
    chk("same_pre", 32'(bus.credit_cnt), 2);
    chk("same_grant", 32'(bus.req_ready), 32'b0001);
    tick();
    chk("same_post", 32'(bus.credit_cnt), 2);
    drv(4'b0000, 1'b1, 1'b0, 1'b0); tick();
    for (int k = 0; k < 2; k++) begin
      drv(4'b0000, 1'b0, 1'b1, 1'b0);
      tick();
    end

    // Overflow: credit return at full count saturates and latches the error.
    drv(4'b0000, 1'b0, 1'b1, 1'b0);
    chk("ovf_pre", 32'(bus.credit_cnt), 4);
    tick();
    chk("ovf_cnt", 32'(bus.credit_cnt), 4);
    chk("ovf_err", 32'(bus.credit_err), 1);
    for (int k = 0; k < 3; k++) begin
      drv(4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("ovf_sticky", 32'(bus.credit_err), 1);

    // Flush with two bytes in flight.
    setdat(3, 8'h3C);
    drv(4'b1000, 1'b1, 1'b0, 1'b0);
    chk("fl_g0", 32'(bus.req_ready), 32'b1000);
    tick();
    drv(4'b1000, 1'b1, 1'b0, 1'b0);
    chk("fl_g1", 32'(bus.req_ready), 32'b1000);
    tick();
    drv(4'b1000, 1'b1, 1'b0, 1'b1);
    chk("fl_no_grant", 32'(bus.req_ready), 0);
    tick();
    drv(4'b1000, 1'b1, 1'b0, 1'b1);
    chk("fl_no_grant2", 32'(bus.req_ready), 0);
    chk("fl_link_idle", 32'(bus.link_valid), 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drv(4'b1000, 1'b1, 1'b1, 1'b1);
      chk("fl_drain_ready", 32'(bus.req_ready), 0);
      tick();
    end
    chk("fl_done_early", 32'(bus.flush_done), 0);
    drv(4'b1000, 1'b1, 1'b0, 1'b1);
    tick();
    chk("fl_done", 32'(bus.flush_done), 1);
    drv(4'b1000, 1'b1, 1'b0, 1'b0);
    chk("fl_idle_resume", 32'(bus.req_ready), 32'b1000);
    tick();
    chk("fl_single_pulse", 32'(bus.flush_done), 0);
    chk("fl_send", 32'(bus.link_valid), 1);

    // Reset while a byte is held.
    rst = 1'b1;
    drv(4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    chk("rst_send_valid", 32'(bus.link_valid), 0);
    chk("rst_send_cred",  32'(bus.credit_cnt), 4);
    chk("rst_send_err",   32'(bus.credit_err), 0);

    // Random traffic against the model.
    v  = '0;
    fl = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      cr = (m_cred < CR) && ($urandom_range(0, 2) == 0);
      lr = ($urandom_range(0, 3) != 0);
      if (!fl && $urandom_range(0, 59) == 0) fl = 1'b1;
      drv(v, lr, cr, fl);
      tick();
      if (m_fdone) fl = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (i == m_last_w || !vbit(v, i)) begin
          if ($urandom_range(0, 1) == 1) begin
            v = v | (4'd1 << i);
            setdat(i, 8'($urandom_range(0, 255)));
          end else begin
            v = v & ~(4'd1 << i);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          v = v & ~(4'd1 << i);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/link_tx_arbiter.md
Name: link_tx_arbiter

Overview:
- Shares the single off-chip transmit byte interface (serializer into the 8-entry nibble buffer) between NUM_REQ requesters.
- Picks requesters by round-robin and presents one byte at a time with valid/ready.
- Gates grants on a credit counter that mirrors free downstream buffer slots; credits come back as credit_ret pulses from the read side.
- A flush handshake drains all in-flight traffic before reconfiguration.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width per request
- CREDITS, 4, downstream byte slots; credit counter width CW = clog2(CREDITS+1)

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req_valid  input  NUM_REQ  per-requester valid
- req_data  input  NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot accept strobe (combinational)
- link_valid  output  1  byte valid toward serializer
- link_data  output  DATA_W  registered byte
- link_src  output  3  registered index of the source requester
- link_ready  input  1  serializer accepts byte
- credit_ret  input  1  one-cycle pulse returning one credit
- flush  input  1  level; request drain
- flush_done  output  1  one-cycle pulse when drained
- credit_cnt  output  CW  current credits
- credit_err  output  1  sticky overflow/underflow flag

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: link_valid=0, link_data=0, link_src=0, credit_cnt=CREDITS, credit_err=0, flush_done=0, rr_ptr=NUM_REQ-1 (so req 0 has first priority), state=IDLE.
- Reset mid-transfer drops the held byte and restores all credits.
- States: IDLE, SEND, DRAIN.
- Grant condition g = (state==IDLE or (state==SEND and link_ready)) and !flush and credit_cnt>0 and |req_valid.
- Winner: first i with req_valid[i], scanning from rr_ptr+1 upward modulo NUM_REQ.
- When g is true:
  - req_ready[winner]=1 in the same cycle; all other req_ready bits are 0.
  - Next edge: link_data<=req_data[winner], link_src<=winner, link_valid<=1, rr_ptr<=winner, credit_cnt decrements, state<=SEND.
- IDLE: with no grant, stay in IDLE. If flush is high, go to DRAIN.
- SEND:
  - link_valid, link_data and link_src stay stable until link_ready.
  - On link_ready with g true: back-to-back grant, stay in SEND. Peak throughput is 1 byte/cycle.
  - On link_ready without g: link_valid<=0, then go to DRAIN if flush is high, else IDLE.
- DRAIN:
  - No grants.
  - When credit_cnt==CREDITS, pulse flush_done for 1 cycle and return to IDLE.
  - If flush is still high in IDLE, DRAIN is re-entered; the bench deasserts flush on flush_done.
- Latency: req_valid to link_valid is 1 cycle.
- Credit arithmetic:
  - Grant and credit_ret in the same cycle: net unchanged.
  - credit_ret alone: +1.
  - credit_ret alone at credit_cnt==CREDITS: count saturates and credit_err<=1.
  - Underflow is impossible by the grant rule; an assertion checks credit_cnt never wraps.
- credit_cnt==0: requests wait with req_ready=0 and link_valid drops after the current handshake. The grant resumes in the cycle after the credit_ret that returns the first credit.
- Requester data must be stable while req_valid is high. Deasserting req_valid before grant is legal: that requester is simply skipped.
- flush asserted in SEND: the held byte still completes, then no new grants.

Optional Feature:
- Macro: LINK_TX_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index with req_valid wins; rr_ptr is not implemented.
- Undefined (default): round-robin as specified.

Test Plan:
- Reset, then all 4 req_valid high with data 0x10,0x21,0x32,0x43, link_ready=1, credit_ret tied to each handshake delayed 2 cycles -> link_src sequence 0,1,2,3,0; link_data 0x10,0x21,0x32,0x43; credit_cnt never below 2.
- Single req 2, data 0x05, link_ready=0 for 3 cycles -> link_valid held 3 cycles with data 0x05; accepted on cycle 4; credit_cnt 3.
- 5 bytes from req 1, no credit_ret -> 4 accepted, credit_cnt=0, req_ready[1]=0. One credit_ret pulse -> 5th byte granted the next cycle.
- Grant and credit_ret in the same cycle at credit_cnt=2 -> credit_cnt stays 2.
- credit_ret at credit_cnt=4 -> credit_cnt stays 4, credit_err=1 and stays set until rst.
- Flush: flush asserted with 2 bytes in flight -> no new req_ready. After 2 credit_ret pulses, flush_done pulses once and state returns to IDLE. Assert rst during SEND -> link_valid=0 and credit_cnt=4 next cycle.
